// File: rtl/pixel_chain_rx_pkg.sv
// Shared types and default geometry for the pixel readout chain receiver.
package pixel_chain_pkg;

    localparam int PIX_WORD_W     = 42;
    localparam int PIX_LANE_W     = 2;
    localparam int BEATS_PER_WORD = PIX_WORD_W / PIX_LANE_W;

    typedef logic [PIX_WORD_W-1:0] pix_word_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DRAIN
    } rx_state_e;

    // Counter width for n values; never zero, even when only one value exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pixel_chain_rx_if.sv
// Pixel word stream from the chain receiver toward the frame packer.
interface pixel_chain_rx_if
    import pixel_chain_pkg::*;
#(
    parameter int WORD_W = PIX_WORD_W,
    parameter int IDX_W  = 3
);

    logic [WORD_W-1:0] pix_data;
    logic [IDX_W-1:0]  pix_idx;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output pix_data,
        output pix_idx,
        output pix_valid,
        input  pix_ready
    );

    modport slave (
        input  pix_data,
        input  pix_idx,
        input  pix_valid,
        output pix_ready
    );

endinterface

// File: rtl/pixel_chain_rx_fifo.sv
// Small synchronous FIFO holding assembled {pix_idx, pix_data} entries.
module pixel_chain_rx_fifo #(
    parameter int DATA_W = 45,
    parameter int DEPTH  = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Masked while empty so the output reads zero out of reset.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge sclk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/pixel_chain_rx.sv
// Pixel chain receiver: loads the chain, shifts out lanes, rebuilds words, streams them out.
// Optional frame/stall statistics counters are enabled with PIXEL_CHAIN_RX_STATS_EN.
module pixel_chain_rx
    import pixel_chain_pkg::*;
#(
    parameter int WORD_W    = PIX_WORD_W,
    parameter int LANE_W    = PIX_LANE_W,
    parameter int NUM_PIX   = 8,
    parameter int BUF_DEPTH = 2
) (
    input  logic              sclk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              chain_load,
    output logic              chain_shift,
    input  logic [LANE_W-1:0] chain_data,
    output logic              frame_done,
`ifdef PIXEL_CHAIN_RX_STATS_EN
    output logic [15:0]       frame_cnt,
    output logic [15:0]       stall_cnt,
`endif
    pixel_chain_rx_if.master  pix
);

    localparam int BEATS  = WORD_W / LANE_W;
    localparam int BEAT_W = idx_width(BEATS);
    localparam int IDX_W  = idx_width(NUM_PIX);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_PIX  = IDX_W'(NUM_PIX - 1);

    rx_state_e                 state;
    rx_state_e                 state_nxt;
    logic [BEAT_W-1:0]         beat_cnt;
    logic [IDX_W-1:0]          pix_cnt;
    logic [WORD_W-1:0]         asm_word;
    logic [WORD_W-1:0]         asm_nxt;
    logic                      last_beat;
    logic                      push;
    logic                      pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [IDX_W+WORD_W-1:0]   fifo_rd;

    assign last_beat  = (beat_cnt == LAST_BEAT);
    assign busy       = (state != IDLE);
    assign push       = chain_shift && last_beat;
    assign pop        = !fifo_empty && pix.pix_ready;
    assign frame_done = pop && (fifo_rd[WORD_W +: IDX_W] == LAST_PIX);

    assign pix.pix_valid = !fifo_empty;
    assign pix.pix_data  = fifo_rd[WORD_W-1:0];
    assign pix.pix_idx   = fifo_rd[WORD_W +: IDX_W];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        chain_load  = 1'b0;
        chain_shift = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD: begin
                chain_load = 1'b1;
                state_nxt  = SHIFT;
            end
            SHIFT: begin
                // Shifting only while a full word could still be stored avoids losing beats.
                chain_shift = !fifo_full;
                if (chain_shift && last_beat && (pix_cnt == LAST_PIX)) state_nxt = DRAIN;
            end
            DRAIN: if (frame_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Current lane merged in, so a completed word can be pushed on its final beat.
    always_comb begin
        asm_nxt = asm_word;
        for (int b = 0; b < BEATS; b++) begin
            if (beat_cnt == BEAT_W'(b)) asm_nxt[b*LANE_W +: LANE_W] = chain_data;
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            pix_cnt  <= '0;
            asm_word <= '0;
        end else begin
            state <= state_nxt;
            if (chain_shift) begin
                asm_word <= asm_nxt;
                if (last_beat) begin
                    beat_cnt <= '0;
                    pix_cnt  <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                end
            end
        end
    end

    pixel_chain_rx_fifo #(
        .DATA_W (IDX_W + WORD_W),
        .DEPTH  (BUF_DEPTH)
    ) u_fifo (
        .sclk      (sclk),
        .rst       (rst),
        .push      (push),
        .push_data ({pix_cnt, asm_nxt}),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef PIXEL_CHAIN_RX_STATS_EN
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (frame_done) frame_cnt <= frame_cnt + 1'b1;
            if ((state == SHIFT) && !chain_shift && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
